// File: rtl/seg_scan_driver_if.sv
// Display/alarm bundle from the watch core to the display back end.
// master = watch side (drives), slave = seg_scan_driver side (samples).
interface seg_scan_driver_if;
    logic [47:0] seg_data;
    logic [7:0]  mode_led_i;
    logic        alarm_i;

    modport master (output seg_data, output mode_led_i, output alarm_i);
    modport slave  (input  seg_data, input  mode_led_i, input  alarm_i);
endinterface

// File: rtl/seg_scan_driver.sv
// Six-digit common-anode 7-segment scanner with LED mirror and buzzer drive.
// Optional DISP_BUZZER_EN: tone + beep envelope for a passive piezo; otherwise level buzzer output.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BUZZ_DIV  = 25000,
    parameter int BEEP_DIV  = 12500000
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   disp,
    output logic [7:0]         seg_o,
    output logic [5:0]         dig_o,
    output logic [7:0]         led_o,
    output logic               buzz_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    // Elaboration-time parameter legality checks.
    if (SCAN_DIV < 2) begin : g_bad_scan
        $error("SCAN_DIV must be >= 2");
    end
    if (BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
        $error("BLANK_CYC must satisfy 1 <= BLANK_CYC < SCAN_DIV");
    end
    if (BUZZ_DIV < 1 || BEEP_DIV < 1) begin : g_bad_buzz
        $error("BUZZ_DIV and BEEP_DIV must be >= 1");
    end

    logic [CNT_W-1:0] cnt_p0;
    logic [2:0]       idx_p0;
    logic [47:0]      shadow_p0;
    logic             alarm_q;

    function automatic logic [5:0] digit_sel(input logic [2:0] idx);
        digit_sel = ~(6'b000001 << idx);
    endfunction

    function automatic logic [7:0] digit_seg(input logic [47:0] frame, input logic [2:0] idx);
        digit_seg = ~frame[8*idx +: 8];
    endfunction

    wire cnt_wrap   = (cnt_p0 == CNT_W'(SCAN_DIV - 1));
    wire frame_head = (cnt_p0 == '0) && (idx_p0 == 3'd0);
    wire in_blank   = (cnt_p0 < CNT_W'(BLANK_CYC));

    // Stage p0: slot counter, digit index and per-frame snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0    <= '0;
            idx_p0    <= 3'd0;
            shadow_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_wrap ? '0 : cnt_p0 + 1'b1;
            if (cnt_wrap) begin
                idx_p0 <= (idx_p0 == 3'd5) ? 3'd0 : idx_p0 + 3'd1;
            end
            if (frame_head) begin
                shadow_p0 <= disp.seg_data;
            end
        end
    end

    // Stage p1: registered pin decode; blank leading part of every slot
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_o <= 8'hFF;
            dig_o <= 6'h3F;
        end else if (in_blank) begin
            seg_o <= 8'hFF;
            dig_o <= 6'h3F;
        end else begin
            seg_o <= digit_seg(shadow_p0, idx_p0);
            dig_o <= digit_sel(idx_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_o   <= 8'h00;
            alarm_q <= 1'b0;
        end else begin
            led_o   <= disp.mode_led_i;
            alarm_q <= disp.alarm_i;
        end
    end

`ifdef DISP_BUZZER_EN
    localparam int BUZZ_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam int BEEP_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

    logic [BUZZ_W-1:0] tone_cnt;
    logic [BEEP_W-1:0] env_cnt;
    logic              tone;
    logic              env;

    wire tone_wrap = (tone_cnt == BUZZ_W'(BUZZ_DIV - 1));
    wire env_wrap  = (env_cnt  == BEEP_W'(BEEP_DIV - 1));

    // Generators idle at zero while no alarm, so each alarm starts with the same phase.
    always_ff @(posedge clk) begin
        if (rst || !alarm_q) begin
            tone_cnt <= '0;
            env_cnt  <= '0;
            tone     <= 1'b0;
            env      <= 1'b0;
        end else begin
            tone_cnt <= tone_wrap ? '0 : tone_cnt + 1'b1;
            env_cnt  <= env_wrap  ? '0 : env_cnt + 1'b1;
            if (tone_wrap) tone <= ~tone;
            if (env_wrap)  env  <= ~env;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) buzz_o <= 1'b0;
        else     buzz_o <= tone & env & alarm_q;
    end
`else
    assign buzz_o = alarm_q;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: scoreboard of expected pin values per clock.
module tb_seg_scan_driver;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int BUZZ_DIV  = 2;
    localparam int BEEP_DIV  = 8;
    localparam int FRAME     = 6 * SCAN_DIV;
    localparam logic [47:0] PATTERN = 48'h20_10_08_04_02_01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_o;
    logic [5:0] dig_o;
    logic [7:0] led_o;
    logic       buzz_o;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .BUZZ_DIV (BUZZ_DIV),
        .BEEP_DIV (BEEP_DIV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .disp  (bus.slave),
        .seg_o (seg_o),
        .dig_o (dig_o),
        .led_o (led_o),
        .buzz_o(buzz_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] dig;
        logic [7:0] seg;
        logic [7:0] led;
        logic       buzz;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          pos;
    logic [47:0] snap;
    int          checks   = 0;
    int          failures = 0;

    // Predict the pins after the coming edge from the inputs driven now, then clock.
    task automatic drive_cycle();
        exp_t x;
        int   c;
        int   s;
        if (rst) begin
            x = '{dig: 6'h3F, seg: 8'hFF, led: 8'h00, buzz: 1'b0};
            pos  = 0;
            snap = '0;
        end else begin
            c = pos % SCAN_DIV;
            s = (pos / SCAN_DIV) % 6;
            x.led  = bus.mode_led_i;
            x.buzz = bus.alarm_i;
            if (c < BLANK_CYC) begin
                x.dig = 6'h3F;
                x.seg = 8'hFF;
            end else begin
                x.dig = ~(6'b000001 << s);
                x.seg = ~snap[8*s +: 8];
            end
            if (pos % FRAME == 0) snap = bus.seg_data;
            pos++;
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.seg_data   = 48'hFFFF_FFFF_FFFF;
        bus.mode_led_i = 8'hA5;
        bus.alarm_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            checks++;
            if ({dig_o, seg_o, led_o, buzz_o} !== {e.dig, e.seg, e.led, e.buzz}) begin
                failures++;
                $display("FAIL reset cyc=%0d got dig=%h seg=%h led=%h buzz=%b exp dig=%h seg=%h led=%h buzz=%b",
                         i, dig_o, seg_o, led_o, buzz_o, e.dig, e.seg, e.led, e.buzz);
            end
        end
        bus.mode_led_i = 8'h00;
        bus.alarm_i    = 1'b0;
    endtask

    task automatic test_scan();
        rst = 1'b0;
        bus.seg_data = PATTERN;
        for (int i = 0; i < 2 * FRAME; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            checks++;
            if ({dig_o, seg_o} !== {e.dig, e.seg}) begin
                failures++;
                $display("FAIL scan cyc=%0d got dig=%h seg=%h exp dig=%h seg=%h", i, dig_o, seg_o, e.dig, e.seg);
            end
        end
    endtask

    task automatic test_no_tear();
        int n;
        n = 0;
        // Advance until digit 2 has just been shown lit, then change the word.
        while (pos % FRAME != 2 * SCAN_DIV + BLANK_CYC + 1 && n < 100) begin
            drive_cycle();
            e = exp_q.pop_front();
            n++;
        end
        checks++;
        if (dig_o !== 6'b111011) begin
            failures++;
            $display("FAIL no_tear_setup got dig=%h exp dig=3b", dig_o);
        end
        bus.seg_data = 48'h0;
        for (int i = 0; i < FRAME + 14; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            checks++;
            if ({dig_o, seg_o} !== {e.dig, e.seg}) begin
                failures++;
                $display("FAIL no_tear cyc=%0d got dig=%h seg=%h exp dig=%h seg=%h", i, dig_o, seg_o, e.dig, e.seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        bus.seg_data = PATTERN;
        while (pos % FRAME != 3 * SCAN_DIV + BLANK_CYC + 1 && n < 100) begin
            drive_cycle();
            e = exp_q.pop_front();
            n++;
        end
        checks++;
        if (dig_o !== 6'b110111) begin
            failures++;
            $display("FAIL reset_mid_setup got dig=%h exp dig=37", dig_o);
        end
        rst = 1'b1;
        drive_cycle();
        e = exp_q.pop_front();
        checks++;
        if ({dig_o, seg_o} !== {6'h3F, 8'hFF}) begin
            failures++;
            $display("FAIL reset_mid_idle got dig=%h seg=%h exp dig=3f seg=ff", dig_o, seg_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * SCAN_DIV + 2; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            checks++;
            if ({dig_o, seg_o} !== {e.dig, e.seg}) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got dig=%h seg=%h exp dig=%h seg=%h", i, dig_o, seg_o, e.dig, e.seg);
            end
        end
    endtask

    task automatic test_leds_buzz();
        bus.mode_led_i = 8'h04;
        for (int i = 0; i < 10; i++) begin
            bus.alarm_i = (i < 5);
            if (i == 7) bus.mode_led_i = 8'h20;
            drive_cycle();
            e = exp_q.pop_front();
            checks++;
            if (led_o !== e.led) begin
                failures++;
                $display("FAIL led cyc=%0d got=%h exp=%h", i, led_o, e.led);
            end
`ifndef DISP_BUZZER_EN
            checks++;
            if (buzz_o !== e.buzz) begin
                failures++;
                $display("FAIL buzz_level cyc=%0d got=%b exp=%b", i, buzz_o, e.buzz);
            end
`endif
        end
        bus.alarm_i = 1'b0;
        drive_cycle();
        e = exp_q.pop_front();
    endtask

`ifdef DISP_BUZZER_EN
    task automatic test_buzzer();
        logic want;
        bus.alarm_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            drive_cycle();
            e = exp_q.pop_front();
            want = (k == 1) ? 1'b0 : ((((k - 2) / BUZZ_DIV) % 2 == 1) && (((k - 2) / BEEP_DIV) % 2 == 1));
            checks++;
            if (buzz_o !== want) begin
                failures++;
                $display("FAIL buzz_tone k=%0d got=%b exp=%b", k, buzz_o, want);
            end
        end
        bus.alarm_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive_cycle();
            e = exp_q.pop_front();
            if (k >= 2) begin
                checks++;
                if (buzz_o !== 1'b0) begin
                    failures++;
                    $display("FAIL buzz_off k=%0d got=%b exp=0", k, buzz_o);
                end
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.seg_data   = '0;
        bus.mode_led_i = '0;
        bus.alarm_i    = 1'b0;
        pos  = 0;
        snap = '0;
        test_reset();
        test_scan();
        test_no_tear();
        test_reset_mid();
        test_leds_buzz();
`ifdef DISP_BUZZER_EN
        test_buzzer();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
